// File: rtl/polyplay_nvram_upload_if.sv
// Bundle of the hps_io ioctl upload channel, CPU pause handshake and CMOS RAM read port.
// The slave modport is the NVRAM upload responder; the master modport is its environment.
interface polyplay_nvram_upload_if #(
    parameter int ADDR_W = 10
);
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              cpu_pause;
    logic              cpu_paused;
    logic              ram_rd;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_ack;
    logic [7:0]        ram_rdata;
    logic              protocol_err;

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, cpu_paused, ram_ack, ram_rdata,
        input  ioctl_din, ioctl_wait, cpu_pause, ram_rd, ram_addr, protocol_err
    );

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, cpu_paused, ram_ack, ram_rdata,
        output ioctl_din, ioctl_wait, cpu_pause, ram_rd, ram_addr, protocol_err
    );
endinterface

// File: rtl/polyplay_nvram_upload.sv
// Serves Poly-Play CMOS RAM bytes to hps_io during an NVRAM upload while the Z80 is held paused.
// Optional NVRAM_CHECKSUM_EN: a read at address SIZE returns the running modulo-256 byte sum.
module polyplay_nvram_upload #(
    parameter int SIZE   = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    polyplay_nvram_upload_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, HALT, READY, FETCH, DRAIN} state_t;

    state_t     state, state_nxt;
    logic       upload_q;
    logic       upload_rise;
    logic       in_range;
    logic       start_fetch;
    logic       oor_read;
    logic       take_byte;
    logic       err_set;
    logic       session_clr;
    logic [7:0] oor_byte;

    always_comb begin
        state_nxt   = state;
        start_fetch = 1'b0;
        oor_read    = 1'b0;
        take_byte   = 1'b0;
        err_set     = 1'b0;
        session_clr = 1'b0;
        upload_rise = bus.ioctl_upload && !upload_q;
        in_range    = (bus.ioctl_addr < 25'(SIZE));
        case (state)
            IDLE: begin
                if (upload_rise) begin
                    state_nxt   = HALT;
                    session_clr = 1'b1;
                end
            end
            HALT: begin
                if (!bus.ioctl_upload)
                    state_nxt = IDLE;
                else if (bus.cpu_paused)
                    state_nxt = READY;
            end
            READY: begin
                if (!bus.ioctl_upload)
                    state_nxt = IDLE;
                else if (bus.ioctl_rd) begin
                    if (in_range) begin
                        start_fetch = 1'b1;
                        state_nxt   = FETCH;
                    end else
                        oor_read = 1'b1;
                end
            end
            FETCH: begin
                if (bus.ram_ack) begin
                    take_byte = 1'b1;
                    state_nxt = bus.ioctl_upload ? READY : IDLE;
                end else if (!bus.ioctl_upload)
                    state_nxt = DRAIN;
            end
            // The RAM arbiter handshake must complete even after the session is gone.
            DRAIN: begin
                if (bus.ram_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.ioctl_rd && state != READY)
            err_set = 1'b1;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            upload_q         <= 1'b0;
            bus.ioctl_din    <= 8'h00;
            bus.ioctl_wait   <= 1'b0;
            bus.cpu_pause    <= 1'b0;
            bus.ram_rd       <= 1'b0;
            bus.ram_addr     <= '0;
            bus.protocol_err <= 1'b0;
        end else begin
            state          <= state_nxt;
            upload_q       <= bus.ioctl_upload;
            bus.cpu_pause  <= (state_nxt != IDLE);
            bus.ioctl_wait <= (state_nxt == HALT) || (state_nxt == FETCH) || (state_nxt == DRAIN);
            bus.ram_rd     <= (state_nxt == FETCH) || (state_nxt == DRAIN);
            if (start_fetch)
                bus.ram_addr <= bus.ioctl_addr[ADDR_W-1:0];
            if (take_byte)
                bus.ioctl_din <= bus.ram_rdata;
            else if (oor_read)
                bus.ioctl_din <= oor_byte;
            if (err_set)
                bus.protocol_err <= 1'b1;
            else if (session_clr)
                bus.protocol_err <= 1'b0;
        end
    end

`ifdef NVRAM_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            csum <= 8'h00;
        else if (session_clr)
            csum <= 8'h00;
        else if (take_byte)
            csum <= csum + bus.ram_rdata;
    end

    assign oor_byte = (bus.ioctl_addr == 25'(SIZE)) ? csum : 8'hFF;
`else
    assign oor_byte = 8'hFF;
`endif
endmodule

// File: tb/tb_polyplay_nvram_upload.sv
// Directed bench for polyplay_nvram_upload with RAM and CPU responder models and a read scoreboard.
module tb_polyplay_nvram_upload;
    localparam int SIZE   = 1024;
    localparam int ADDR_W = 10;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;

    polyplay_nvram_upload_if #(.ADDR_W(ADDR_W)) bus ();

    polyplay_nvram_upload #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    logic [7:0] mem [SIZE];
    logic [7:0] exp_q [$];
    logic [7:0] csum_model;
    int         ack_delay = 3;
    int         ram_cnt   = 0;
    int         cpu_cnt   = 0;
    int         checks    = 0;
    int         passed    = 0;

    // RAM arbiter model: ack arrives ack_delay cycles after ram_rd is first seen high.
    initial begin
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = 8'hA5;
        forever begin
            @(posedge clk_sys);
            #1;
            bus.ram_ack   = 1'b0;
            bus.ram_rdata = 8'hA5;
            if (bus.ram_rd) begin
                ram_cnt++;
                if (ram_cnt == ack_delay + 1) begin
                    bus.ram_ack   = 1'b1;
                    bus.ram_rdata = mem[bus.ram_addr];
                    ram_cnt       = 0;
                end
            end else
                ram_cnt = 0;
        end
    end

    // CPU model: acknowledges the pause 5 cycles after it is requested.
    initial begin
        bus.cpu_paused = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (bus.cpu_pause)
                cpu_cnt++;
            else
                cpu_cnt = 0;
            bus.cpu_paused = (cpu_cnt >= 6);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passed);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drives one read strobe, then waits for the byte and compares it against the scoreboard.
    task automatic do_read(input logic [24:0] addr, input logic [7:0] exp, input int exp_wait);
        int wc;
        logic [7:0] want;
        bus.ioctl_addr = addr;
        bus.ioctl_rd   = 1'b1;
        exp_q.push_back(exp);
        tick();
        bus.ioctl_rd = 1'b0;
        if (exp_wait > 0) begin
            check($sformatf("ram_addr@%0h", addr), bus.ram_addr, addr[ADDR_W-1:0]);
            csum_model = csum_model + exp;
        end else
            check($sformatf("oor_no_ram_rd@%0h", addr), bus.ram_rd, 0);
        wc = 0;
        while (bus.ioctl_wait && wc < 50) begin
            wc++;
            tick();
        end
        check($sformatf("wait_cycles@%0h", addr), wc, exp_wait);
        check($sformatf("queue_depth@%0h", addr), exp_q.size(), 1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check($sformatf("din@%0h", addr), bus.ioctl_din, want);
    endtask

    task automatic rise();
        bus.ioctl_upload = 1'b1;
        csum_model       = 8'h00;
        tick();
        check("start_pause", bus.cpu_pause, 1);
        check("start_wait", bus.ioctl_wait, 1);
    endtask

    task automatic wait_ready(input int exp_halt);
        int c;
        c = 0;
        while (bus.ioctl_wait && c < 40) begin
            c++;
            tick();
        end
        check("halt_cycles", c, exp_halt);
        check("ready_pause", bus.cpu_pause, 1);
    endtask

    task automatic end_session();
        check("pause_before_fall", bus.cpu_pause, 1);
        bus.ioctl_upload = 1'b0;
        tick();
        check("pause_after_fall", bus.cpu_pause, 0);
        check("wait_after_fall", bus.ioctl_wait, 0);
        tick();
        tick();
    endtask

    initial begin
        int c;
        logic [7:0] exp_sum;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = '0;
        csum_model       = 8'h00;
        for (int i = 0; i < SIZE; i++)
            mem[i] = i[7:0];

        // Reset state
        tick();
        tick();
        check("rst_din", bus.ioctl_din, 8'h00);
        check("rst_wait", bus.ioctl_wait, 0);
        check("rst_pause", bus.cpu_pause, 0);
        check("rst_ram_rd", bus.ram_rd, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_err", bus.protocol_err, 0);
        reset = 1'b0;
        tick();
        tick();
        check("idle_pause", bus.cpu_pause, 0);

        // Full sequential dump, then the bytes past the end
        rise();
        wait_ready(6);
        ack_delay = 3;
        for (int a = 0; a < SIZE; a++)
            do_read(25'(a), mem[a], 4);
`ifdef NVRAM_CHECKSUM_EN
        exp_sum = csum_model;
`else
        exp_sum = 8'hFF;
`endif
        do_read(25'(SIZE), exp_sum, 0);
        do_read(25'(SIZE + 1), 8'hFF, 0);
        check("dump_err", bus.protocol_err, 0);
        end_session();

        // Protocol violations in HALT and FETCH
        rise();
        bus.ioctl_addr = 25'h5;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        check("halt_rd_err", bus.protocol_err, 1);
        check("halt_rd_no_ram", bus.ram_rd, 0);
        wait_ready(5);
        bus.ioctl_addr = 25'h7;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        tick();
        bus.ioctl_addr = 25'h9;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        check("fetch_rd_err", bus.protocol_err, 1);
        c = 0;
        while (bus.ioctl_wait && c < 40) begin
            c++;
            tick();
        end
        check("fetch_rd_wait_left", c, 2);
        check("fetch_rd_din", bus.ioctl_din, 8'h07);
        check("fetch_rd_addr", bus.ram_addr, 10'h7);
        tick();
        tick();
        check("no_extra_ram_rd", bus.ram_rd, 0);
        check("no_extra_wait", bus.ioctl_wait, 0);
        end_session();

        // New session clears the error; then abort mid-fetch
        rise();
        check("err_cleared", bus.protocol_err, 0);
        wait_ready(6);
        do_read(25'h10, mem[16'h10], 4);
        ack_delay      = 10;
        bus.ioctl_addr = 25'h20;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        c = 0;
        while (bus.ram_rd && c < 40) begin
            c++;
            if (c == 3)
                bus.ioctl_upload = 1'b0;
            tick();
        end
        check("abort_ram_rd_cycles", c, 11);
        check("abort_pause", bus.cpu_pause, 0);
        check("abort_wait", bus.ioctl_wait, 0);
        check("abort_din_kept", bus.ioctl_din, 8'h10);
        tick();
        tick();
        check("abort_idle_ram_rd", bus.ram_rd, 0);

        // Asynchronous reset while a fetch is outstanding
        ack_delay = 3;
        rise();
        wait_ready(6);
        bus.ioctl_addr = 25'h33;
        bus.ioctl_rd   = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        check("pre_rst_ram_rd", bus.ram_rd, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_ram_rd", bus.ram_rd, 0);
        check("async_rst_wait", bus.ioctl_wait, 0);
        check("async_rst_pause", bus.cpu_pause, 0);
        check("async_rst_din", bus.ioctl_din, 8'h00);
        bus.ioctl_upload = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Next session: address 0, then back-to-back reads with immediate ack
        rise();
        wait_ready(6);
        do_read(25'h0, mem[0], 4);
        ack_delay = 0;
        for (int a = 0; a < 16; a++)
            do_read(25'(a), mem[a], 1);
`ifdef NVRAM_CHECKSUM_EN
        exp_sum = csum_model;
`else
        exp_sum = 8'hFF;
`endif
        do_read(25'(SIZE), exp_sum, 0);
        end_session();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
